// File: rtl/cpu_pkg.sv
// cpu_pkg - shared definitions for multicycle_cpu.
//   Opcodes of the 16-bit instruction set, FSM state type, 3-bit ALU
//   control codes and small decode helpers.
//   Optional feature macro: CPU_BNE_EN (opcode 1001 decodes as bne when
//   defined, and is illegal otherwise).
package cpu_pkg;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_LW, OP_SW, OP_SLT, OP_BEQ: return 1'b1;
`ifdef CPU_BNE_EN
      OP_BNE:                       return 1'b1;
`endif
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  // Branches compare by subtraction and test the zero flag.
  function automatic logic [2:0] alu_ctl_of(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
      OP_AND:                 return ALU_AND;
      OP_OR:                  return ALU_OR;
      OP_SLT:                 return ALU_SLT;
      default:                return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu - combinational ALU of multicycle_cpu.
//   ctl    : 3-bit ALU control code (cpu_pkg ALU_*)
//   a, b   : DATA_W-bit operands
//   result : DATA_W-bit result, wraps modulo 2^DATA_W; slt is signed, 1/0
//   zero   : result == 0
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        ctl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu - multi-cycle core for the 16-bit-instruction MIPS subset.
//   Shared instruction/data memory port with request/ready handshake.
//   Parameters: DATA_W (16..64) datapath width, ADDR_W word-address/PC width.
//   Ports:
//     clock, reset          : rising-edge clock, synchronous active-high reset
//     mem_req/we/addr/wdata : memory request (held stable until mem_ready)
//     mem_rdata, mem_ready  : read data (instruction in [15:0]), completion
//     pc, ir                : current PC and latched instruction
//     wb_valid, wb_data     : one-cycle pulse and value of a register write
//     illegal               : one-cycle pulse when an undefined opcode decodes
//   Optional feature macro: CPU_BNE_EN (enables bne on opcode 1001).
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  state_t            state, state_next;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] a_q, b_q, alu_out_q, mdr_q;

  logic [3:0] op;
  logic [1:0] rs, rt, rd, wb_dst;
  logic [DATA_W-1:0] imm_ext, alu_b, alu_result, wb_value;
  logic [ADDR_W-1:0] br_off;
  logic [2:0] alu_ctl;
  logic alu_zero, xfer_done, is_branch, br_taken;

  assign op      = ir[15:12];
  assign rs      = ir[11:10];
  assign rt      = ir[9:8];
  assign rd      = ir[7:6];
  assign imm_ext = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign br_off  = {{(ADDR_W-8){ir[7]}}, ir[7:0]};

  assign alu_ctl = alu_ctl_of(op);
  assign alu_b   = (op == OP_ADDI || op == OP_LW || op == OP_SW) ? imm_ext : b_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .ctl    (alu_ctl),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign xfer_done = mem_req && mem_ready;
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  // bne can only reach EXEC when op_legal admits it.
  assign br_taken  = ((op == OP_BEQ) && alu_zero) || ((op == OP_BNE) && !alu_zero);

  assign wb_dst   = op_is_rtype(op) ? rd : rt;
  assign wb_value = (op == OP_LW) ? mdr_q : alu_out_q;
  assign wb_valid = (state == WB);
  assign wb_data  = wb_valid ? wb_value : '0;
  assign illegal  = (state == DECODE) && !op_legal(op);

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (xfer_done) state_next = DECODE;
      DECODE: state_next = op_legal(op) ? EXEC : FETCH;
      EXEC: begin
        if (is_branch)                         state_next = FETCH;
        else if (op == OP_LW || op == OP_SW)   state_next = MEM;
        else                                   state_next = WB;
      end
      MEM:    if (xfer_done) state_next = (op == OP_SW) ? FETCH : WB;
      WB:     state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      // NOTE: the register file is only four words of flops, so it is
      // cleared by reset like any other state; $0 is simply never written.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        // mem_req is raised one cycle after entering FETCH/MEM and dropped
        // on the completing edge, so requests never run back to back.
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata[15:0];
            pc      <= pc + ADDR_W'(1);
          end
        end
        DECODE: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
        end
        EXEC: begin
          alu_out_q <= alu_result;
          // pc already points past the branch, so target = old PC+1+imm.
          if (is_branch && br_taken) pc <= pc + br_off;
        end
        MEM: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_SW);
            mem_addr  <= alu_out_q[ADDR_W-1:0];
            mem_wdata <= b_q;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mdr_q   <= mem_rdata;
          end
        end
        WB: begin
          if (wb_dst != 2'd0) regs[wb_dst] <= wb_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu - directed self-checking bench for multicycle_cpu.
//   Behavioural memory with per-address wait states; monitors log
//   write-backs, illegal pulses, stores, PC jumps and request stability.
module tb_multicycle_cpu;

  localparam int DW = 16;
  localparam int AW = 10;

  localparam logic [3:0] T_ADD = 4'b0000, T_SUB = 4'b0001, T_AND = 4'b0010,
                         T_OR = 4'b0011, T_ADDI = 4'b0100, T_LW = 4'b0101,
                         T_SW = 4'b0110, T_SLT = 4'b0111, T_BEQ = 4'b1000,
                         T_BNE = 4'b1001;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, wb_data;
  logic [15:0]   ir;
  logic          wb_valid, illegal;

  always #5 clock = ~clock;

  multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .ir        (ir),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [1024];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [AW-1:0] wait_addr = '1;
  int            wait_n = 0;
  int            lat = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_req && ((mem_addr != wait_addr) || (lat >= wait_n));

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
    if (!mem_req || mem_ready) lat <= 0;
    else lat <= lat + 1;
  end

  // ---------------- monitors ----------------
  int            cyc = 0;
  int            wb_cyc[$];
  logic [DW-1:0] wb_val[$];
  logic [AW-1:0] wb_pc[$];
  int            jmp_cyc[$];
  logic [AW-1:0] jmp_pc[$];
  int            ill_cnt = 0, wr_cnt = 0, stab_err = 0, b2b_err = 0;
  logic [AW-1:0] wr_addr = '0, prev_pc = '0, prev_addr = '0;
  logic [DW-1:0] wr_data = '0, prev_wdata = '0;
  logic          prev_req = 1'b0, prev_we = 1'b0, prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (wb_valid) begin
      wb_cyc.push_back(cyc);
      wb_val.push_back(wb_data);
      wb_pc.push_back(pc);
    end
    if (illegal) ill_cnt <= ill_cnt + 1;
    if (mem_req && mem_ready && mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (!reset && pc != prev_pc && pc != AW'(prev_pc + 1)) begin
      jmp_cyc.push_back(cyc);
      jmp_pc.push_back(pc);
    end
    if (mem_req && prev_req &&
        (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
      stab_err <= stab_err + 1;
    if (mem_req && prev_done) b2b_err <= b2b_err + 1;
    prev_pc    <= pc;
    prev_req   <= mem_req;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_done  <= mem_req && mem_ready;
  end

  // ---------------- helpers ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  int          rel_cyc = 0;
  logic [15:0] prog_q[$];

  function automatic logic [15:0] i_ins(input logic [3:0] op, input int s, input int t, input int imm);
    return {op, 2'(s), 2'(t), 8'(imm)};
  endfunction

  function automatic logic [15:0] r_ins(input logic [3:0] op, input int s, input int t, input int d);
    return {op, 2'(s), 2'(t), 2'(d), 6'b0};
  endfunction

  // Holds reset, loads prog_q at address 0.., sets wait states, releases.
  task automatic start_prog(input logic [AW-1:0] waddr, input int wn);
    @(negedge clock);
    reset     = 1'b1;
    wait_addr = waddr;
    wait_n    = wn;
    foreach (prog_q[i]) begin
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      ld_data = DW'(prog_q[i]);
      @(negedge clock);
    end
    ld_en = 1'b0;
    @(negedge clock);
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_wb(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (wb_val.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (wb_val.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: writebacks seen %0d, required %0d", tag, wb_val.size(), n);
    end
  endtask

  task automatic wait_jmp(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (jmp_pc.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (jmp_pc.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: jumps seen %0d, required %0d", tag, jmp_pc.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks += 9;
    if (pc !== '0)        begin n_fail++; $display("FAIL reset_pc: got %0h want 0", pc); end
    if (ir !== '0)        begin n_fail++; $display("FAIL reset_ir: got %0h want 0", ir); end
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    if (mem_addr !== '0)  begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    if (wb_data !== '0)   begin n_fail++; $display("FAIL reset_wb_data: got %0h want 0", wb_data); end
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_alu_seq();
    logic [DW-1:0] exp_v[$];
    int base;
    prog_q = '{i_ins(T_ADDI, 0, 1, 15), i_ins(T_ADDI, 0, 2, 7), r_ins(T_AND, 1, 2, 3),
               r_ins(T_SUB, 1, 3, 2), r_ins(T_OR, 2, 3, 2), r_ins(T_ADD, 2, 3, 3),
               r_ins(T_SLT, 3, 2, 1), r_ins(T_SLT, 2, 3, 1), i_ins(T_ADDI, 0, 3, -1),
               r_ins(T_SLT, 3, 2, 1), i_ins(T_BEQ, 0, 0, -1)};
    exp_v = '{DW'(15), DW'(7), DW'(7), DW'(8), DW'(15), DW'(22), DW'(0), DW'(1),
              {DW{1'b1}}, DW'(1)};
    base = wb_val.size();
    start_prog('1, 0);
    wait_wb(base + 10, 200, "alu_seq");
    if (wb_val.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (wb_val[base+i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL alu_wb_data[%0d]: got %0h want %0h", i, wb_val[base+i], exp_v[i]);
        end
        n_checks++;
        if (i == 0) begin
          if (wb_cyc[base] - rel_cyc !== 4) begin
            n_fail++;
            $display("FAIL alu_first_latency: got %0d want 4", wb_cyc[base] - rel_cyc);
          end
        end else if (wb_cyc[base+i] - wb_cyc[base+i-1] !== 5) begin
          n_fail++;
          $display("FAIL alu_cpi[%0d]: got %0d want 5", i, wb_cyc[base+i] - wb_cyc[base+i-1]);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    int base, wbase;
    prog_q = '{i_ins(T_ADDI, 0, 1, 3), i_ins(T_SW, 0, 1, 4), i_ins(T_LW, 0, 2, 4),
               i_ins(T_BEQ, 0, 0, -1)};
    base  = wb_val.size();
    wbase = wr_cnt;
    start_prog(AW'(4), 3);
    wait_wb(base + 2, 200, "mem");
    repeat (5) @(negedge clock);
    if (wb_val.size() >= base + 2) begin
      n_checks += 3;
      if (wb_val[base] !== DW'(3)) begin n_fail++; $display("FAIL mem_addi: got %0h want 3", wb_val[base]); end
      if (wb_val[base+1] !== DW'(3)) begin n_fail++; $display("FAIL mem_lw_data: got %0h want 3", wb_val[base+1]); end
      // sw 6+3 cycles, lw 7+3 cycles between the two write-backs
      if (wb_cyc[base+1] - wb_cyc[base] !== 19) begin
        n_fail++; $display("FAIL mem_cpi_sw_lw: got %0d want 19", wb_cyc[base+1] - wb_cyc[base]);
      end
    end
    n_checks += 5;
    if (wr_cnt - wbase !== 1) begin n_fail++; $display("FAIL mem_store_count: got %0d want 1", wr_cnt - wbase); end
    if (wr_addr !== AW'(4)) begin n_fail++; $display("FAIL mem_store_addr: got %0h want 4", wr_addr); end
    if (wr_data !== DW'(3)) begin n_fail++; $display("FAIL mem_store_data: got %0h want 3", wr_data); end
    if (stab_err !== 0) begin n_fail++; $display("FAIL mem_req_stability: got %0d changes want 0", stab_err); end
    if (b2b_err !== 0) begin n_fail++; $display("FAIL mem_back_to_back: got %0d want 0", b2b_err); end
  endtask

  task automatic test_beq_loop();
    int jbase;
    prog_q = '{i_ins(T_ADDI, 0, 0, 0), i_ins(T_ADDI, 0, 0, 0), i_ins(T_ADDI, 0, 0, 0),
               i_ins(T_ADDI, 0, 0, 0), i_ins(T_ADDI, 0, 0, 0), i_ins(T_BEQ, 0, 0, -1)};
    jbase = jmp_pc.size();
    start_prog('1, 0);
    wait_jmp(jbase + 3, 100, "beq_loop");
    if (jmp_pc.size() >= jbase + 3) begin
      n_checks++;
      if (jmp_cyc[jbase] - rel_cyc !== 29) begin
        n_fail++; $display("FAIL beq_first_taken: got cycle %0d want 29", jmp_cyc[jbase] - rel_cyc);
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (jmp_pc[jbase+i] !== AW'(5)) begin
          n_fail++; $display("FAIL beq_target[%0d]: got %0h want 5", i, jmp_pc[jbase+i]);
        end
        if (i > 0) begin
          n_checks++;
          if (jmp_cyc[jbase+i] - jmp_cyc[jbase+i-1] !== 4) begin
            n_fail++; $display("FAIL beq_cpi[%0d]: got %0d want 4", i, jmp_cyc[jbase+i] - jmp_cyc[jbase+i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_beq_not_taken();
    int base, jbase;
    prog_q = '{i_ins(T_ADDI, 0, 1, 1), i_ins(T_ADDI, 0, 1, 1), i_ins(T_ADDI, 0, 1, 1),
               i_ins(T_ADDI, 0, 1, 1), i_ins(T_ADDI, 0, 1, 1), i_ins(T_BEQ, 0, 1, 5),
               i_ins(T_ADDI, 0, 2, 9), i_ins(T_BEQ, 0, 0, -1)};
    base  = wb_val.size();
    jbase = jmp_pc.size();
    start_prog('1, 0);
    wait_wb(base + 6, 200, "beq_nt");
    wait_jmp(jbase + 1, 50, "beq_nt_loop");
    if (wb_val.size() >= base + 6) begin
      n_checks += 3;
      if (wb_val[base+5] !== DW'(9)) begin n_fail++; $display("FAIL beq_nt_next: got %0h want 9", wb_val[base+5]); end
      if (wb_pc[base+5] !== AW'(7)) begin n_fail++; $display("FAIL beq_nt_pc: got %0h want 7", wb_pc[base+5]); end
      if (wb_cyc[base+5] - wb_cyc[base+4] !== 9) begin
        n_fail++; $display("FAIL beq_nt_cpi: got %0d want 9", wb_cyc[base+5] - wb_cyc[base+4]);
      end
    end
    if (jmp_pc.size() >= jbase + 1) begin
      n_checks++;
      if (jmp_pc[jbase] !== AW'(7)) begin n_fail++; $display("FAIL beq_nt_first_jump: got %0h want 7", jmp_pc[jbase]); end
    end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] exp_v[$];
    int base, ibase, exp_ill, exp_gap;
    prog_q = '{i_ins(T_ADDI, 0, 1, 2), i_ins(T_BNE, 1, 0, 2), i_ins(T_ADDI, 0, 2, 5),
               i_ins(T_ADDI, 0, 3, 6), i_ins(T_ADDI, 0, 3, 7), 16'hF000,
               i_ins(T_BEQ, 0, 0, -1)};
`ifdef CPU_BNE_EN
    exp_v = '{DW'(2), DW'(7)};
    exp_ill = 1;
    exp_gap = 9;
`else
    exp_v = '{DW'(2), DW'(5), DW'(6), DW'(7)};
    exp_ill = 2;
    exp_gap = 8;
`endif
    base  = wb_val.size();
    ibase = ill_cnt;
    start_prog('1, 0);
    wait_wb(base + exp_v.size(), 200, "illegal");
    repeat (15) @(negedge clock);
    n_checks += 2;
    if (wb_val.size() - base !== exp_v.size()) begin
      n_fail++; $display("FAIL illegal_wb_count: got %0d want %0d", wb_val.size() - base, exp_v.size());
    end
    if (ill_cnt - ibase !== exp_ill) begin
      n_fail++; $display("FAIL illegal_pulses: got %0d want %0d", ill_cnt - ibase, exp_ill);
    end
    if (wb_val.size() >= base + exp_v.size()) begin
      foreach (exp_v[i]) begin
        n_checks++;
        if (wb_val[base+i] !== exp_v[i]) begin
          n_fail++; $display("FAIL illegal_wb[%0d]: got %0h want %0h", i, wb_val[base+i], exp_v[i]);
        end
      end
      n_checks++;
      if (wb_cyc[base+1] - wb_cyc[base] !== exp_gap) begin
        n_fail++; $display("FAIL illegal_gap: got %0d want %0d", wb_cyc[base+1] - wb_cyc[base], exp_gap);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, k, nwb;
    prog_q = '{r_ins(T_ADD, 3, 0, 1), i_ins(T_LW, 0, 2, 4), r_ins(T_ADD, 2, 2, 1),
               i_ins(T_BEQ, 0, 0, -1), 16'h0055};
    base = wb_val.size();
    start_prog(AW'(4), 5);
    wait_wb(base + 1, 50, "rst_regs");
    if (wb_val.size() >= base + 1) begin
      n_checks++;
      if (wb_val[base] !== '0) begin n_fail++; $display("FAIL rst_regfile_cleared: got %0h want 0", wb_val[base]); end
    end
    k = 0;
    while (!(mem_req && !mem_we && mem_addr == AW'(4)) && k < 50) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (!(mem_req && !mem_we && mem_addr == AW'(4))) begin
      n_fail++; $display("FAIL rst_find_lw: got no lw request, want one within 50 cycles");
    end else begin
      reset = 1'b1;
      nwb = wb_val.size();
      @(negedge clock);
      n_checks += 4;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_req: got %b want 0", mem_req); end
      if (pc !== '0) begin n_fail++; $display("FAIL rst_mid_pc: got %0h want 0", pc); end
      if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wb_valid: got %b want 0", wb_valid); end
      if (wb_val.size() !== nwb) begin n_fail++; $display("FAIL rst_mid_no_wb: got %0d want %0d", wb_val.size(), nwb); end
      reset = 1'b0;
      base = wb_val.size();
      wait_wb(base + 3, 200, "rst_rerun");
      if (wb_val.size() >= base + 3) begin
        n_checks += 3;
        if (wb_val[base] !== '0) begin n_fail++; $display("FAIL rst_rerun_add: got %0h want 0", wb_val[base]); end
        if (wb_val[base+1] !== DW'('h55)) begin n_fail++; $display("FAIL rst_rerun_lw: got %0h want 55", wb_val[base+1]); end
        if (wb_val[base+2] !== DW'('hAA)) begin n_fail++; $display("FAIL rst_rerun_add2: got %0h want aa", wb_val[base+2]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_mem_wait();
    test_beq_loop();
    test_beq_not_taken();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
